// File: rtl/vga_pattern_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_pkg : pattern encodings and colour constants.  Rev 1.0
// ---------------------------------------------------------------------------
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_SCROLL  = 2'd2,
    PAT_GRID    = 2'd3
  } pattern_e;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_GRID_BG = 12'h003;

  function automatic pattern_e next_pattern(input pattern_e p);
    case (p)
      PAT_BARS:    return PAT_CHECKER;
      PAT_CHECKER: return PAT_SCROLL;
      PAT_SCROLL:  return PAT_GRID;
      default:     return PAT_BARS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_gen_if : coordinate/sync stream in, RGB/sync stream out. Rev 1.0
// ---------------------------------------------------------------------------
interface vga_pattern_gen_if;
  import vga_pattern_pkg::*;

  logic [9:0] x;
  logic [9:0] y;
  logic       in_frame;
  logic       hsync;
  logic       vsync;
  logic       pat_next;
  logic       auto_en;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       hsync_o;
  logic       vsync_o;
  logic       de_o;
  pattern_e   pattern;

  modport master (
    output x, y, in_frame, hsync, vsync, pat_next, auto_en,
    input  r, g, b, hsync_o, vsync_o, de_o, pattern
  );

  modport slave (
    input  x, y, in_frame, hsync, vsync, pat_next, auto_en,
    output r, g, b, hsync_o, vsync_o, de_o, pattern
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_ctrl : frame/button request tracking and pattern state. Rev 1.0
// ---------------------------------------------------------------------------
module vga_pattern_ctrl
  import vga_pattern_pkg::*;
#(
  parameter int VSYNC_POL   = 1,
  parameter int AUTO_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_s1,
  input  logic       pat_next,
  input  logic       auto_en,
  output pattern_e   pattern,
  output logic [7:0] frame_cnt
);

  localparam logic       VS_ACTIVE  = (VSYNC_POL != 0);
  localparam logic [7:0] DWELL_LAST = 8'(AUTO_FRAMES - 1);

  pattern_e   state, state_nxt;
  logic       vs_prev, pn_prev;
  logic       pending, pending_nxt;
  logic [7:0] dwell, dwell_nxt, frame_cnt_nxt;
  logic       frame_edge, pat_edge, auto_hit;

  assign frame_edge = (vsync_s1 == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
  assign pat_edge   = pat_next && !pn_prev;
  assign pattern    = state;

  // History resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PAT_BARS;
      vs_prev   <= 1'b0;
      pn_prev   <= 1'b1;
      pending   <= 1'b0;
      dwell     <= 8'd0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      vs_prev   <= vsync_s1;
      pn_prev   <= pat_next;
      pending   <= pending_nxt;
      dwell     <= dwell_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // The auto request joins the pending one at the boundary where the dwell
  // expires, so AUTO_FRAMES is the exact period and a coinciding manual
  // request merges into the same single advance.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending || pat_edge;
    dwell_nxt     = auto_en ? dwell : 8'd0;
    frame_cnt_nxt = frame_cnt;
    auto_hit      = 1'b0;
    if (frame_edge) begin
      frame_cnt_nxt = frame_cnt + 8'd1;
      auto_hit      = auto_en && (dwell == DWELL_LAST);
      if (pending || auto_hit) begin
        state_nxt   = next_pattern(state);
        pending_nxt = pat_edge;
        dwell_nxt   = 8'd0;
      end else if (auto_en) begin
        dwell_nxt = dwell + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_gen : two-stage test-card colour pipeline after VGA timing. Rev 1.0
// ---------------------------------------------------------------------------
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int VSYNC_POL   = 1,
  parameter int AUTO_FRAMES = 120
) (
  input  logic              clk,
  input  logic              reset,
  vga_pattern_gen_if.slave  bus
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  logic [9:0]  x_s1, y_s1;
  logic        de_s1, hs_s1, vs_s1;
  pattern_e    pattern;
  logic [7:0]  frame_cnt;
  logic [3:0]  scroll_r;
  logic        grid_line;
  logic [11:0] colour;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_s1  <= 10'd0;
      y_s1  <= 10'd0;
      de_s1 <= 1'b0;
      hs_s1 <= 1'b0;
      vs_s1 <= 1'b0;
    end else begin
      x_s1  <= bus.x;
      y_s1  <= bus.y;
      de_s1 <= bus.in_frame;
      hs_s1 <= bus.hsync;
      vs_s1 <= bus.vsync;
    end
  end

  vga_pattern_ctrl #(
    .VSYNC_POL   (VSYNC_POL),
    .AUTO_FRAMES (AUTO_FRAMES)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .vsync_s1  (vs_s1),
    .pat_next  (bus.pat_next),
    .auto_en   (bus.auto_en),
    .pattern   (pattern),
    .frame_cnt (frame_cnt)
  );

  assign bus.pattern = pattern;

  always_comb begin
    scroll_r  = x_s1[7:4] + frame_cnt[3:0];
    grid_line = (x_s1[4:0] == 5'd0) || (y_s1[4:0] == 5'd0) ||
                (x_s1 == X_LAST)    || (y_s1 == Y_LAST);
    colour    = COL_BLACK;
    if (de_s1) begin
      case (pattern)
        PAT_BARS:    colour = {{4{x_s1[9]}}, {4{x_s1[8]}}, {4{x_s1[7]}}};
        PAT_CHECKER: colour = (x_s1[5] ^ y_s1[5]) ? COL_WHITE : COL_BLACK;
        PAT_SCROLL:  colour = {scroll_r, y_s1[8:5], frame_cnt[7:4]};
        default:     colour = grid_line ? COL_WHITE : COL_GRID_BG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.r       <= 4'd0;
      bus.g       <= 4'd0;
      bus.b       <= 4'd0;
      bus.hsync_o <= 1'b0;
      bus.vsync_o <= 1'b0;
      bus.de_o    <= 1'b0;
    end else begin
      {bus.r, bus.g, bus.b} <= colour;
      bus.hsync_o           <= hs_s1;
      bus.vsync_o           <= vs_s1;
      bus.de_o              <= de_s1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen : scoreboard bench for the test-card colour stage. Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;
  import vga_pattern_pkg::*;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_pattern_gen_if bus ();

  vga_pattern_gen #(
    .H_ACTIVE    (800),
    .V_ACTIVE    (600),
    .VSYNC_POL   (1),
    .AUTO_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [11:0] rgb;
    logic [2:0]  syn;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rst_drv, pn_drv, auto_drv;
  int   exp_pat, exp_fc;
  int   auto_exp[6] = '{1, 2, 2, 3, 3, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [11:0] model_rgb(input int pat, input int fc, input int px,
                                            input int py, input bit de);
    int idx;
    logic [3:0] r, g, b;
    if (!de) return 12'h000;
    case (pat)
      0: begin
        idx = px / 128;
        r = ((idx & 4) != 0) ? 4'hF : 4'h0;
        g = ((idx & 2) != 0) ? 4'hF : 4'h0;
        b = ((idx & 1) != 0) ? 4'hF : 4'h0;
        return {r, g, b};
      end
      1: return ((((px / 32) + (py / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2: begin
        r = 4'((px / 16 + fc) % 16);
        g = 4'((py / 32) % 16);
        b = 4'((fc / 16) % 16);
        return {r, g, b};
      end
      default: return ((px % 32 == 0) || (py % 32 == 0) || (px == 799) || (py == 599))
                       ? 12'hFFF : 12'h003;
    endcase
  endfunction

  task automatic step(input int px, input int py, input bit de, input bit hs,
                      input bit vs, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst_drv;
    bus.pat_next = pn_drv;
    bus.auto_en  = auto_drv;
    bus.x        = 10'(px);
    bus.y        = 10'(py);
    bus.in_frame = de;
    bus.hsync    = hs;
    bus.vsync    = vs;
    e.cyc = cyc;
    e.rgb = model_rgb(exp_pat, exp_fc, px, py, de);
    e.syn = {hs, vs, de};
    e.chk = chk && !rst_drv;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, L, L, L, H);
  endtask

  task automatic press();
    pn_drv = 1'b1;
    idle(2);
    pn_drv = 1'b0;
    idle(2);
  endtask

  // Vsync pulse; optionally raise pat_next in the cycle the boundary commits.
  task automatic frame(input bit press_at_commit);
    for (int i = 0; i < 4; i++) begin
      if (press_at_commit && i == 1) pn_drv = 1'b1;
      step(0, 0, L, L, H, H);
    end
    for (int i = 0; i < 4; i++) step(0, 0, L, L, L, H);
    if (press_at_commit) pn_drv = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic check_pat(input string tag, input int p);
    @(negedge clk);
    check_val(tag, 32'(bus.pattern), 32'(p));
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc + 2 <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.chk && mon_e.cyc + 2 == cyc) begin
        check_val("rgb", 32'({bus.r, bus.g, bus.b}), 32'(mon_e.rgb));
        check_val("sync_de", 32'({bus.hsync_o, bus.vsync_o, bus.de_o}), 32'(mon_e.syn));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rst_drv = 1'b1; pn_drv = 1'b0; auto_drv = 1'b0;
    bus.x = '0; bus.y = '0; bus.in_frame = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0;
    bus.pat_next = 1'b0; bus.auto_en = 1'b0;
    exp_pat = 0; exp_fc = 0;

    repeat (4) step(0, 0, L, L, L, L);
    @(negedge clk);
    check_val("rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'h0);
    check_val("rst_sync", 32'({bus.hsync_o, bus.vsync_o, bus.de_o}), 32'h0);
    check_val("rst_pattern", 32'(bus.pattern), 32'(PAT_BARS));
    rst_drv = 1'b0;
    idle(3);

    // BARS across all eight columns with a toggling hsync
    for (int i = 0; i < 8; i++) step(i * 128, 10, H, bit'(i % 2), L, H);
    step(640, 20, H, H, L, H);
    step(700, 20, L, H, L, H);

    press(); press(); press();
    check_pat("no_adv_midframe", 0);
    frame(0); exp_pat = 1;
    check_pat("single_adv", 1);

    step(32, 0, H, L, L, H);
    step(32, 32, H, L, L, H);
    step(32, 0, L, H, L, H);
    step(0, 32, H, L, L, H);
    step(64, 0, H, L, L, H);
    frame(0);
    check_pat("hold_no_req", 1);

    press(); frame(0); exp_pat = 2;
    check_pat("to_scroll", 2);
    for (int k = 0; k < 17; k++) begin
      step(16, 0, H, L, L, H);
      step(16, 64, H, L, L, H);
      frame(0);
    end
    step(16, 0, H, L, L, H);

    press(); frame(0); exp_pat = 3;
    check_pat("to_grid", 3);
    step(0, 5, H, L, L, H);   step(5, 0, H, L, L, H);
    step(5, 5, H, L, L, H);   step(799, 5, H, L, L, H);
    step(5, 599, H, L, L, H); step(798, 598, H, L, L, H);
    step(33, 64, H, L, L, H); step(31, 31, H, L, L, H);

    // A press landing on the commit cycle carries over to the next boundary
    press(); frame(1); exp_pat = 0;
    check_pat("commit_wrap", 0);
    frame(0); exp_pat = 1;
    check_pat("held_edge_adv", 1);
    frame(0);
    check_pat("held_edge_once", 1);

    auto_drv = 1'b1;
    idle(2);
    for (int k = 0; k < 6; k++) begin
      frame(0); exp_pat = auto_exp[k];
      check_pat("auto_cycle", exp_pat);
      step(160, 40, H, L, L, H);
    end
    frame(0);
    check_pat("auto_dwell", 0);
    press(); frame(0); exp_pat = 1;
    check_pat("auto_manual_merge", 1);
    frame(0);
    check_pat("auto_manual_once", 1);
    frame(0); exp_pat = 2;
    check_pat("auto_resume", 2);
    auto_drv = 1'b0;
    idle(2);

    press(); frame(0); exp_pat = 3;
    check_pat("grid_again", 3);

    // Reset mid-line in GRID with a request pending, button held through it
    press();
    step(5, 5, H, H, L, H); step(0, 5, H, H, L, H);
    step(6, 6, H, H, L, L); step(7, 6, H, H, L, L);
    rst_drv = 1'b1; pn_drv = 1'b1;
    step(8, 6, H, H, L, L);
    @(negedge clk);
    @(negedge clk);
    check_val("midrst_rgb", 32'({bus.r, bus.g, bus.b}), 32'h0);
    check_val("midrst_sync", 32'({bus.hsync_o, bus.vsync_o, bus.de_o}), 32'h0);
    check_val("midrst_pattern", 32'(bus.pattern), 32'(PAT_BARS));
    exp_pat = 0; exp_fc = 0;
    step(9, 6, H, H, L, L);
    rst_drv = 1'b0;
    step(10, 6, H, H, L, L);
    step(11, 6, H, H, L, L);
    step(200, 6, H, L, L, H);
    idle(2);
    frame(0);
    check_pat("no_req_after_rst", 0);
    pn_drv = 1'b0;
    idle(2);
    press(); frame(0); exp_pat = 1;
    check_pat("req_after_rst", 1);
    step(32, 0, H, L, L, H);
    step(32, 32, H, L, L, H);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
